mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 126 ++++++++++++
 tb/tb_mult_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Two-port arbiter sharing one 32x32 sign-magnitude multiplier.
// Each operation runs IDLE -> MUL -> RESP; the priority pointer flips only when a response completes.
module mult_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [63:0] rsp0_result,
  output logic [63:0] rsp1_result,
  output logic        busy,
  output logic [15:0] op_count,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // ready may depend on valid; a requester must hold valid and its payload until the transfer.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] result_q, result_d;
  logic [15:0] count_q, count_d;

  logic        grant1;
  logic        any_req;
  logic [62:0] mul_mag;
  logic [63:0] mul_prod;

  // The shared multiplier: b[31] deliberately stays in the magnitude.
  assign mul_mag  = 63'(a_q[30:0]) * 63'(b_q);
  assign mul_prod = {a_q[31] ^ b_q[31], mul_mag};

  assign any_req = req0_valid | req1_valid;
  assign grant1  = req1_valid & (~req0_valid | prio_q);

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    count_d    = count_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          req0_ready = ~grant1;
          req1_ready = grant1;
          owner_d    = grant1;
          a_d        = grant1 ? req1_a : req0_a;
          b_d        = grant1 ? req1_b : req0_b;
          state_d    = S_MUL;
        end
      end
      S_MUL: begin
        result_d = mul_prod;
        state_d  = S_RESP;
      end
      S_RESP: begin
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
        if (owner_q ? rsp1_ready : rsp0_ready) begin
          state_d = S_IDLE;
          prio_d  = ~owner_q;
          count_d = count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Handshake outputs are silenced while reset is held.
    if (rst) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      count_q  <= count_d;
    end
  end

  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign busy        = (state_q != S_IDLE) & ~rst;
  assign op_count    = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomised and directed bench for mult_arbiter against a transaction-level model.
module tb_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [63:0] rsp0_result, rsp1_result;
  logic        busy;
  logic [15:0] op_count;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mult_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req1_valid  (req1_valid),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp0_valid  (rsp0_valid),
    .rsp1_valid  (rsp1_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp1_ready  (rsp1_ready),
    .rsp0_result (rsp0_result),
    .rsp1_result (rsp1_result),
    .busy        (busy),
    .op_count    (op_count),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;

  // Transaction-level model: one outstanding op, a "product computed" flag, a fairness bit.
  bit          m_busy     = 1'b0;
  bit          m_computed = 1'b0;
  bit          m_owner    = 1'b0;
  bit          m_prio     = 1'b0;
  logic [15:0] m_count    = '0;
  logic [63:0] exp_q[$];
  int          grant_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] sm_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mag;
    mag = 64'(a & 32'h7FFF_FFFF) * 64'(b);
    return {a[31] ^ b[31], mag[62:0]};
  endfunction

  // Called at a negedge with inputs already driven; compares, crosses one rising edge, updates model.
  task automatic step();
    int win;
    bit e_v0, e_v1;
    #1;
    win = -1;
    if (!rst && !m_busy) begin
      if (req0_valid && req1_valid) win = m_prio ? 1 : 0;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
    end
    e_v0 = !rst && m_busy && m_computed && !m_owner;
    e_v1 = !rst && m_busy && m_computed && m_owner;
    check("req0_ready", req0_ready, win == 0);
    check("req1_ready", req1_ready, win == 1);
    check("rsp0_valid", rsp0_valid, e_v0);
    check("rsp1_valid", rsp1_valid, e_v1);
    check("busy", busy, !rst && m_busy);
    check("op_count", op_count, m_count);
    if ((e_v0 || e_v1) && exp_q.size() > 0)
      check("rsp_result", m_owner ? rsp1_result : rsp0_result, exp_q[0]);
    @(posedge clk);
    if (rst) begin
      m_busy = 0; m_computed = 0; m_prio = 0; m_count = '0;
      exp_q.delete();
    end else if (win >= 0) begin
      m_busy = 1; m_computed = 0; m_owner = (win == 1);
      exp_q.push_back(win == 1 ? sm_mul(req1_a, req1_b) : sm_mul(req0_a, req0_b));
      grant_log.push_back(win);
    end else if (m_busy && !m_computed) begin
      m_computed = 1;
    end else if (m_busy && (m_owner ? rsp1_ready : rsp0_ready)) begin
      m_busy = 0; m_computed = 0; m_prio = !m_owner; m_count = m_count + 16'd1;
      void'(exp_q.pop_front());
      n_done++;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; step(); step();
    rst = 0;
  endtask

  task automatic do_op(input bit p, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] lit, input string name);
    bit got;
    got = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    if (p) begin req1_valid = 1; req1_a = a; req1_b = b; end
    else   begin req0_valid = 1; req0_a = a; req0_b = b; end
    #1 check({name, "_accept"}, p ? req1_ready : req0_ready, 1);
    step();
    req0_valid = 0; req1_valid = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      #1;
      if (p ? rsp1_valid : rsp0_valid) begin
        check(name, p ? rsp1_result : rsp0_result, lit);
        got = 1;
      end
      step();
    end
    if (!got) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_done;
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_op_count", op_count, 16'h0);
    check("reset_busy", busy, 0);
    check("reset_result0", rsp0_result, 64'h0);
    check("reset_result1", rsp1_result, 64'h0);
    check("model_pin_sign", sm_mul(32'h8000_0002, 32'h4), 64'h8000_0000_0000_0008);
    rst = 0;
    step();

    // Single op with explicit latency checks.
    req0_valid = 1; req0_a = 3; req0_b = 5; rsp0_ready = 1;
    #1 check("single_accept", req0_ready, 1);
    step();
    req0_valid = 0;
    #1 check("single_mul_no_rsp", rsp0_valid, 0);
    step();
    #1 check("single_rsp_valid", rsp0_valid, 1);
    check("single_result", rsp0_result, 64'h0000_0000_0000_000F);
    step();
    #1 check("single_count", op_count, 16'd1);
    check("single_idle", busy, 0);
    step();

    do_op(0, 32'h8000_0002, 32'h0000_0004, 64'h8000_0000_0000_0008, "sign_a");
    do_op(1, 32'h0000_0003, 32'h8000_0001, 64'h8000_0001_8000_0003, "sign_b31");
    do_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h7FFF_FFFE_8000_0001, "max_mag");

    // Contention from reset: both ports always valid.
    do_reset();
    grant_log.delete();
    start_done = n_done;
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 24 && n_done < start_done + 4; i++) begin
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      step();
    end
    idle_inputs();
    #1 check("contention_count", op_count, 16'd4);
    check("contention_grants", grant_log.size(), 4);
    if (grant_log.size() >= 4) begin
      check("grant_0", grant_log[0], 0);
      check("grant_1", grant_log[1], 1);
      check("grant_2", grant_log[2], 0);
      check("grant_3", grant_log[3], 1);
    end
    step();

    // Back-pressure on port 1 while port 0 waits.
    req1_valid = 1; req1_a = 7; req1_b = 9; rsp1_ready = 0;
    step();
    req1_valid = 0; req1_a = $urandom; req1_b = $urandom;
    step();
    req0_valid = 1; req0_a = 2; req0_b = 11; rsp0_ready = 1;
    for (int i = 0; i < 10; i++) begin
      #1 check("bp_rsp1_valid", rsp1_valid, 1);
      check("bp_result", rsp1_result, 64'd63);
      check("bp_req0_blocked", req0_ready, 0);
      step();
    end
    rsp1_ready = 1;
    #1 check("bp_handshake_no_accept", req0_ready, 0);
    step();
    rsp1_ready = 0;
    #1 check("bp_idle_next", busy, 0);
    check("bp_req0_now_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    repeat (3) step();
    #1 check("bp_req0_done_count", op_count, 16'd6);

    // Reset during MUL aborts the op.
    do_reset();
    req0_valid = 1; req0_a = 2; req0_b = 2; rsp0_ready = 1;
    step();
    req0_valid = 0; rst = 1;
    #1 check("rst_busy_low", busy, 0);
    step();
    rst = 0;
    #1 check("rst_abort_idle", busy, 0);
    check("rst_abort_no_rsp", rsp0_valid, 0);
    check("rst_abort_count", op_count, 16'd0);
    repeat (3) step();
    do_op(0, 32'd6, 32'd7, 64'd42, "post_rst_op");
    #1 check("post_rst_count", op_count, 16'd1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
      rsp0_ready = $urandom_range(0, 1);
      rsp1_ready = $urandom_range(0, 1);
      step();
    end
    rst = 0;
    idle_inputs();
    rsp0_ready = 1; rsp1_ready = 1;
    repeat (4) step();

    // Counter wrap from a preloaded 0xFFFF.
    idle_inputs();
    force dut.count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    step();
    release dut.count_q;
    #1 check("wrap_preload", op_count, 16'hFFFF);
    do_op(1, 32'd10, 32'd10, 64'd100, "wrap_op");
    #1 check("wrap_count", op_count, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
